// File: rtl/abc_stim_pkg.sv
// Shared types for the a/b/c stimulus sequencer.
package abc_stim_pkg;

  localparam int PATTERN_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AUTO = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/btn_conditioner.sv
// Push-button conditioner: synchronizer chain, debounce filter and
// rising-edge detector producing a single registered step pulse per press.
module btn_conditioner #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_in,
  output logic level_out,
  output logic rise_pulse
);

  localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       db_cnt;
  logic                   level_q;
  logic                   level_d;
  logic                   sync_lvl;

  assign sync_lvl  = sync_q[SYNC_STAGES-1];
  assign level_out = level_q;

  // Metastability chain for the raw button.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
  end

  // Accept a new level only after it has differed for DB_CYCLES straight clocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt  <= '0;
      level_q <= 1'b0;
    end else if (sync_lvl == level_q) begin
      db_cnt  <= '0;
    end else if (db_cnt == CNT_LAST) begin
      db_cnt  <= '0;
      level_q <= ~level_q;
    end else begin
      db_cnt  <= db_cnt + 1'b1;
    end
  end

  // One-cycle pulse on the filtered rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_d    <= 1'b0;
      rise_pulse <= 1'b0;
    end else begin
      level_d    <= level_q;
      rise_pulse <= level_q & ~level_d;
    end
  end

endmodule

// File: rtl/abc_stimulus_seq.sv
// Stimulus sequencer for the 3-input gate network: steps a/b/c through all
// eight combinations, manually from a push-button or automatically on a tick.
module abc_stimulus_seq
  import abc_stim_pkg::*;
#(
  parameter int TICK_DIV    = 100_000_000,
  parameter int DB_CYCLES   = 1_000_000,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 btn_step,
  input  logic                 run_en,
  input  logic                 sweep_once,
  output logic                 a,
  output logic                 b,
  output logic                 c,
  output logic [PATTERN_W-1:0] pattern,
  output logic                 valid,
  output logic                 wrap,
  output logic                 done
);

  localparam int TICK_W = $clog2(TICK_DIV);
  localparam logic [TICK_W-1:0]    TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [PATTERN_W-1:0] PAT_MAX   = '1;

  state_t                 state;
  logic [TICK_W-1:0]      tick_cnt;
  logic [SYNC_STAGES-1:0] run_sync;
  logic [SYNC_STAGES-1:0] sweep_sync;
  logic                   run_s;
  logic                   sweep_s;
  logic                   btn_level;
  logic                   btn_rise;
  logic                   step_pulse;
  logic                   tick_last;

  btn_conditioner #(
    .SYNC_STAGES (SYNC_STAGES),
    .DB_CYCLES   (DB_CYCLES)
  ) u_btn (
    .clk        (clk),
    .rst        (rst),
    .raw_in     (btn_step),
    .level_out  (btn_level),
    .rise_pulse (btn_rise)
  );

  // A press counts only while the filtered button is still held.
  assign step_pulse = btn_rise & btn_level;
  assign run_s      = run_sync[SYNC_STAGES-1];
  assign sweep_s    = sweep_sync[SYNC_STAGES-1];
  assign tick_last  = (tick_cnt == TICK_LAST);

  assign a = pattern[2];
  assign b = pattern[1];
  assign c = pattern[0];

  // Synchronizers for the two slide switches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_sync   <= '0;
      sweep_sync <= '0;
    end else begin
      run_sync   <= {run_sync[SYNC_STAGES-2:0], run_en};
      sweep_sync <= {sweep_sync[SYNC_STAGES-2:0], sweep_once};
    end
  end

  // Sequencer FSM with registered pattern, strobes and done flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pattern  <= '0;
      tick_cnt <= '0;
      valid    <= 1'b0;
      wrap     <= 1'b0;
      done     <= 1'b0;
    end else begin
      valid <= 1'b0;
      wrap  <= 1'b0;
      case (state)
        IDLE: begin
          if (step_pulse) begin
            pattern <= pattern + 1'b1;
            valid   <= 1'b1;
            wrap    <= (pattern == PAT_MAX);
          end
          if (run_s) begin
            state    <= AUTO;
            tick_cnt <= '0;
          end
        end
        AUTO: begin
          if (!run_s) begin
            // Leaving auto-run wins over a coincident terminal tick.
            state    <= IDLE;
            tick_cnt <= '0;
          end else if (tick_last) begin
            tick_cnt <= '0;
            if (sweep_s && (pattern == PAT_MAX)) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              pattern <= pattern + 1'b1;
              valid   <= 1'b1;
              wrap    <= (pattern == PAT_MAX);
            end
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        DONE: begin
          if (!run_s) begin
            state   <= IDLE;
            pattern <= '0;
            done    <= 1'b0;
            valid   <= (pattern != '0);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_abc_stimulus_seq.sv
// Directed bench for abc_stimulus_seq with TICK_DIV=5, DB_CYCLES=4, SYNC_STAGES=2.
module tb_abc_stimulus_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_step = 1'b0;
  logic       run_en = 1'b0;
  logic       sweep_once = 1'b0;
  logic       a, b, c, valid, wrap, done;
  logic [2:0] pattern;

  int checks = 0;
  int failures = 0;
  int vcnt = 0;
  int wcnt = 0;
  int v0, w0;

  abc_stimulus_seq #(
    .TICK_DIV    (5),
    .DB_CYCLES   (4),
    .SYNC_STAGES (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_step   (btn_step),
    .run_en     (run_en),
    .sweep_once (sweep_once),
    .a          (a),
    .b          (b),
    .c          (c),
    .pattern    (pattern),
    .valid      (valid),
    .wrap       (wrap),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Count strobe pulses seen at each rising edge.
  always @(posedge clk) begin
    if (valid === 1'b1) vcnt <= vcnt + 1;
    if (wrap === 1'b1)  wcnt <= wcnt + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // Reset values
    wait_neg(3);
    chk("reset_pattern", 32'(pattern), 0);
    chk("reset_abc", 32'({a, b, c}), 0);
    chk("reset_valid", 32'(valid), 0);
    chk("reset_wrap", 32'(wrap), 0);
    chk("reset_done", 32'(done), 0);
    rst = 1'b0;
    wait_neg(5);
    chk("idle_hold", 32'(pattern), 0);

    // Clean press: first sample at the next edge, pattern 7 edges later
    v0 = vcnt;
    btn_step = 1'b1;
    wait_neg(7);
    chk("press_early", 32'(pattern), 0);
    wait_neg(1);
    chk("press_pattern", 32'(pattern), 1);
    chk("press_valid", 32'(valid), 1);
    chk("press_abc", 32'({a, b, c}), 1);
    wait_neg(1);
    chk("press_valid_clear", 32'(valid), 0);
    wait_neg(1);
    btn_step = 1'b0;
    wait_neg(15);
    chk("press_count", 32'(vcnt - v0), 1);
    chk("press_hold", 32'(pattern), 1);

    // Bounce: 2-clock toggles, then held high
    v0 = vcnt;
    for (int i = 0; i < 12; i++) begin
      btn_step = ((i / 2) % 2 == 0);
      wait_neg(1);
    end
    btn_step = 1'b1;
    wait_neg(20);
    chk("bounce_count", 32'(vcnt - v0), 1);
    chk("bounce_pattern", 32'(pattern), 2);
    btn_step = 1'b0;
    wait_neg(15);

    // Glitch of 3 clocks is rejected
    v0 = vcnt;
    btn_step = 1'b1;
    wait_neg(3);
    btn_step = 1'b0;
    wait_neg(12);
    chk("glitch_count", 32'(vcnt - v0), 0);
    chk("glitch_pattern", 32'(pattern), 2);

    // Auto free-run from pattern 2, press ignored, run_en drop on terminal tick
    v0 = vcnt;
    w0 = wcnt;
    run_en = 1'b1;
    for (int t = 1; t <= 55; t++) begin
      wait_neg(1);
      if (t == 9)  btn_step = 1'b1;
      if (t == 19) btn_step = 1'b0;
      if (t == 45) run_en = 1'b0;
      if (t >= 8 && t <= 43 && (t - 8) % 5 == 0) begin
        chk("auto_pattern", 32'(pattern), 32'((2 + (t - 3) / 5) % 8));
        chk("auto_valid", 32'(valid), 1);
        chk("auto_wrap", 32'(wrap), 32'(((2 + (t - 3) / 5) % 8) == 0));
      end
      if (t == 7)  chk("auto_first_wait", 32'(pattern), 2);
      if (t == 10) chk("auto_gap_valid", 32'(valid), 0);
      if (t == 34) chk("auto_wrap_clear", 32'(wrap), 0);
      if (t == 48) begin
        chk("drop_pattern", 32'(pattern), 2);
        chk("drop_valid", 32'(valid), 0);
      end
    end
    chk("auto_valid_count", 32'(vcnt - v0), 8);
    chk("auto_wrap_count", 32'(wcnt - w0), 1);
    chk("drop_hold", 32'(pattern), 2);

    // Step pulse coincides with run_s rising
    btn_step = 1'b1;
    wait_neg(5);
    run_en = 1'b1;
    wait_neg(3);
    chk("sim_pattern", 32'(pattern), 3);
    chk("sim_valid", 32'(valid), 1);
    wait_neg(2);
    btn_step = 1'b0;
    wait_neg(2);
    chk("sim_hold", 32'(pattern), 3);
    wait_neg(1);
    chk("sim_next", 32'(pattern), 4);
    chk("sim_next_valid", 32'(valid), 1);
    wait_neg(5);
    chk("pre_reset_pattern", 32'(pattern), 5);

    // Asynchronous reset mid-sweep
    #2 rst = 1'b1;
    #1;
    chk("rst_pattern", 32'(pattern), 0);
    chk("rst_abc", 32'({a, b, c}), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_done", 32'(done), 0);
    run_en = 1'b0;
    wait_neg(2);
    rst = 1'b0;
    v0 = vcnt;
    wait_neg(12);
    chk("rst_hold_pattern", 32'(pattern), 0);
    chk("rst_hold_count", 32'(vcnt - v0), 0);

    // Single sweep from 0
    v0 = vcnt;
    w0 = wcnt;
    run_en = 1'b1;
    sweep_once = 1'b1;
    for (int t = 1; t <= 53; t++) begin
      wait_neg(1);
      if (t >= 8 && t <= 38 && (t - 8) % 5 == 0) begin
        chk("sweep_pattern", 32'(pattern), 32'((t - 3) / 5));
        chk("sweep_valid", 32'(valid), 1);
      end
      if (t == 42) chk("done_early", 32'(done), 0);
      if (t == 43) begin
        chk("sweep_done", 32'(done), 1);
        chk("sweep_held", 32'(pattern), 7);
        chk("sweep_no_adv", 32'(valid), 0);
      end
      if (t == 50) begin
        chk("done_stay", 32'(done), 1);
        chk("done_pattern", 32'(pattern), 7);
        run_en = 1'b0;
      end
      if (t == 52) chk("done_still", 32'(done), 1);
      if (t == 53) begin
        chk("exit_pattern", 32'(pattern), 0);
        chk("exit_done", 32'(done), 0);
        chk("exit_valid", 32'(valid), 1);
        chk("exit_wrap", 32'(wrap), 0);
      end
    end
    wait_neg(2);
    chk("sweep_valid_count", 32'(vcnt - v0), 8);
    chk("sweep_wrap_count", 32'(wcnt - w0), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
